spi_master_gen: RTL
===================

SPI_MASTER_GEN -- requirements
Module: spi_master_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 8, word length in bits (valid range 4..32).
REQ-002 SHALL have parameter DIV_W, default 16, width of div_factor.
REQ-003 SHALL have port clk  input  1  system clock; the block uses this one clock only, all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port div_factor  input  DIV_W  SCLK half-period in clk cycles; 0 is treated as 1.
REQ-006 SHALL have ports cpol, cpha, lsb_first  input  1 each  SPI mode and bit order.
REQ-007 SHALL have port start  input  1  word request, qualified by ready.
REQ-008 SHALL have port data_in  input  DATA_W  word to transmit.
REQ-009 SHALL have port command  input  1  level driven onto dc for this word (0 command, 1 RAM data).
REQ-010 SHALL have port last  input  1  release sce after this word.
REQ-011 SHALL have port miso  input  1  serial data in.
REQ-012 SHALL have ports ready, busy, done  output  1 each  accept window, frame active, 1-cycle word-complete pulse.
REQ-013 SHALL have port data_out  output  DATA_W  last received word.
REQ-014 SHALL have ports sclk, mosi, sce, dc, rst  output  1 each  SPI clock, serial out, chip select (active-low), data/command, display reset (active-low).

Function
REQ-015 SHALL implement states IDLE, SETUP, SHIFT, WAIT, TEARDOWN.
REQ-016 ready SHALL be 1 only in IDLE and WAIT; a word is accepted on a clk edge with start=1 and ready=1.
REQ-017 On acceptance: latch data_in, command->dc, last; sce=0; enter SETUP. From IDLE also latch div_factor, cpol, cpha, lsb_first.
REQ-018 Mode/divider inputs SHALL be ignored while sce=0 (locked for whole burst).
REQ-019 SETUP SHALL last one half-period with sclk=cpol; if cpha=0, mosi presents the first bit on entry to SETUP.
REQ-020 SHIFT SHALL produce exactly 2*DATA_W sclk toggles, one per half-period.
REQ-021 cpha=0: sample miso on odd edges, drive next bit on even edges; cpha=1: drive on odd edges, sample on even edges.
REQ-022 Bit order SHALL be MSB-first when lsb_first=0, else LSB-first, for both mosi and miso.
REQ-023 After the final edge (sclk back at cpol): data_out updated, done=1 for one cycle in the same cycle; then WAIT if last=0, else TEARDOWN.
REQ-024 WAIT SHALL hold sce=0, sclk=cpol, busy=1 indefinitely until next accept.
REQ-025 TEARDOWN SHALL hold sce=0 one half-period, then sce=1, busy=0, state IDLE.
REQ-026 start while ready=0 SHALL be ignored (no queuing, no error).
REQ-027 Word latency with divider D: accept-to-done = (2*DATA_W+1)*D clk cycles (+1 for register stage, fixed, documented).
REQ-028 busy SHALL be 1 in every state except IDLE.
REQ-029 dc SHALL change only on acceptance, never during SHIFT.

Reset
REQ-030 reset=0 SHALL asynchronously force: state IDLE, sce=1, sclk=0, mosi=0, dc=0, rst=0, busy=0, done=0, ready=0, data_out=0, counters 0.
REQ-031 First clk edge after reset release SHALL set rst=1, ready=1; rst stays 1 until next reset.
REQ-032 Reset mid-frame SHALL abort without done pulse; sclk returns to 0 regardless of cpol until next accept latches cpol.

Structure
REQ-033 A shared package spi_pkg SHALL hold the state enum and mode encoding constants (MODE0..MODE3).
REQ-034 One sub-module spi_tick_gen SHALL generate the half-period tick from the latched divider, cleared on acceptance.

Verification
REQ-035 Mode 0, D=2, MSB-first, data_in=0xA5, last=1, miso loop-back -> mosi 1,0,1,0,0,1,0,1; data_out=0xA5; done after 34 cycles; sce high after TEARDOWN.
REQ-036 Mode 3, lsb_first=1, data_in=0x81, miso tied 1 -> idle sclk=1, mosi 1,0,0,0,0,0,0,1, data_out=0xFF.
REQ-037 Burst 3 words (0x21 cmd, 0x90 cmd, 0x55 data, last on third) -> sce low continuously, dc 0,0,1, three done pulses.
REQ-038 div_factor=0 -> identical waveform to div_factor=1; changing div_factor/cpol in WAIT -> no effect.
REQ-039 start during SHIFT -> ignored, data_out unchanged from in-flight word.
REQ-040 reset asserted at edge 5 of a word -> all outputs at reset values immediately, no done, rst=0 then 1 after release.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI master definitions: FSM state encoding and the {cpol,cpha} mode constants.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        WAIT,
        TEARDOWN
    } spi_state_t;

    // Mode encoding is {cpol, cpha}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    function automatic logic [1:0] mode_encode(input logic cpol, input logic cpha);
        return cpol ? (cpha ? MODE3 : MODE2) : (cpha ? MODE1 : MODE0);
    endfunction

    function automatic logic mode_cpha(input logic [1:0] mode);
        return (mode == MODE1) || (mode == MODE3);
    endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period tick generator: one-cycle tick every max(div,1) clk cycles, restartable by clear.
module spi_tick_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_reg;
    logic [DIV_W-1:0] limit;

    // A divider of zero behaves exactly like a divider of one.
    assign limit = (div == '0) ? '0 : div - DIV_W'(1);
    assign tick  = (cnt_reg == limit);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg <= '0;
        end else if (clear || tick) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + DIV_W'(1);
        end
    end

endmodule

// File: rtl/spi_master_gen.sv
// SPI master for display-style links: per-word handshake, bursts under one chip select,
// mode/divider locked for the whole burst, data/command line and display reset.
module spi_master_gen
    import spi_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DIV_W-1:0]  div_factor,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsb_first,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    input  logic              command,
    input  logic              last,
    input  logic              miso,
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] data_out,
    output logic              sclk,
    output logic              mosi,
    output logic              sce,
    output logic              dc,
    output logic              rst
);

    localparam int EW = $clog2(2 * DATA_W) + 1;
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W - 1);

    spi_state_t state_reg, state_next;

    logic [DIV_W-1:0]  div_reg;
    logic [1:0]        mode_reg;
    logic              lsb_reg, last_reg;
    logic [DATA_W-1:0] tx_reg, rx_reg, data_out_reg, rx_next;
    logic [EW-1:0]     edge_cnt_reg;
    logic              sclk_reg, mosi_reg, sce_reg, dc_reg, rst_reg, done_reg;
    logic              tick, accept, shift_tick, last_edge, odd_edge;
    logic              cpha_lock, cpha_now, lsb_now, drive_edge, sample_edge;

    function automatic logic first_bit(input logic [DATA_W-1:0] v, input logic lsb);
        return lsb ? v[0] : v[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] v, input logic lsb);
        return lsb ? (v >> 1) : (v << 1);
    endfunction

    spi_tick_gen #(.DIV_W(DIV_W)) u_tick (
        .clk   (clk),
        .reset (reset),
        .clear (accept),
        .div   (div_reg),
        .tick  (tick)
    );

    // The first word of a burst uses the live mode inputs; later words use the locked copy.
    assign cpha_lock   = mode_cpha(mode_reg);
    assign cpha_now    = (state_reg == IDLE) ? cpha : cpha_lock;
    assign lsb_now     = (state_reg == IDLE) ? lsb_first : lsb_reg;
    assign accept      = start && ready;
    assign shift_tick  = (state_reg == SHIFT) && tick;
    assign last_edge   = (edge_cnt_reg == LAST_EDGE);
    assign odd_edge    = ~edge_cnt_reg[0];
    assign drive_edge  = shift_tick && (cpha_lock ? odd_edge : (!odd_edge && !last_edge));
    assign sample_edge = shift_tick && (cpha_lock ? !odd_edge : odd_edge);
    assign rx_next     = lsb_reg ? {miso, rx_reg[DATA_W-1:1]} : {rx_reg[DATA_W-2:0], miso};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:     if (accept) state_next = SETUP;
            SETUP:    if (tick) state_next = SHIFT;
            SHIFT:    if (tick && last_edge) state_next = last_reg ? TEARDOWN : WAIT;
            WAIT:     if (accept) state_next = SETUP;
            TEARDOWN: if (tick) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // rst_reg gates ready so nothing is accepted in the cycle reset is released.
    always_comb begin
        ready = ((state_reg == IDLE) || (state_reg == WAIT)) && rst_reg;
        busy  = (state_reg != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_reg      <= '0;
            mode_reg     <= MODE0;
            lsb_reg      <= 1'b0;
            last_reg     <= 1'b0;
            tx_reg       <= '0;
            rx_reg       <= '0;
            data_out_reg <= '0;
            edge_cnt_reg <= '0;
            sclk_reg     <= 1'b0;
            mosi_reg     <= 1'b0;
            sce_reg      <= 1'b1;
            dc_reg       <= 1'b0;
            rst_reg      <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            rst_reg  <= 1'b1;
            done_reg <= 1'b0;
            if (accept) begin
                if (state_reg == IDLE) begin
                    div_reg  <= div_factor;
                    mode_reg <= mode_encode(cpol, cpha);
                    lsb_reg  <= lsb_first;
                    sclk_reg <= cpol;
                end
                dc_reg       <= command;
                last_reg     <= last;
                sce_reg      <= 1'b0;
                edge_cnt_reg <= '0;
                if (!cpha_now) begin
                    mosi_reg <= first_bit(data_in, lsb_now);
                    tx_reg   <= shift_out(data_in, lsb_now);
                end else begin
                    tx_reg   <= data_in;
                end
            end
            if (shift_tick) begin
                sclk_reg     <= ~sclk_reg;
                edge_cnt_reg <= edge_cnt_reg + EW'(1);
                if (sample_edge) rx_reg <= rx_next;
                if (drive_edge) begin
                    mosi_reg <= first_bit(tx_reg, lsb_reg);
                    tx_reg   <= shift_out(tx_reg, lsb_reg);
                end
                // With cpha=1 the final edge is also the last sample edge.
                if (last_edge) begin
                    done_reg     <= 1'b1;
                    data_out_reg <= sample_edge ? rx_next : rx_reg;
                end
            end
            if ((state_reg == TEARDOWN) && tick) sce_reg <= 1'b1;
        end
    end

    assign done     = done_reg;
    assign data_out = data_out_reg;
    assign sclk     = sclk_reg;
    assign mosi     = mosi_reg;
    assign sce      = sce_reg;
    assign dc       = dc_reg;
    assign rst      = rst_reg;

endmodule
